// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants, FSM state type and bit-timing helper for the RS232 frame receiver
//
// Contents:
//   PARITY_NONE/ODD/EVEN : parity mode encodings for the PARITY parameter
//   state_e              : receiver FSM states
//   sample_point()       : clock-cycle offset (from the start edge) of the centre of slot k

package rs232_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Slot k spans [k*unit, (k+1)*unit) clocks; its centre is rounded to the
  // nearest clock and shifted by one because the timer starts at 0.
  function automatic int sample_point(input real unit_clks, input int k);
    return int'(unit_clks * (real'(k) + 0.5)) - 1;
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// rtl/rs232_sync.sv - two-flop synchroniser for an asynchronous single-bit input
//
// Ports:
//   clock_i : system clock
//   reset_i : synchronous active-high reset, loads RESET_VALUE into both flops
//   d_i     : asynchronous input
//   q_o     : synchronised output

module rs232_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ff_q <= {2{RESET_VALUE}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/rs232_receive_frame.sv
// rtl/rs232_receive_frame.sv - parametrised RS232 frame receiver with error flags and a one-entry output buffer
//
// Ports:
//   clock        : system clock
//   reset        : synchronous active-high reset
//   rs232_txd    : asynchronous serial line, idle high
//   data         : received word, valid while valid=1
//   valid        : buffered word available
//   ready        : consumer takes the word when valid && ready
//   parity_error : parity mismatch on the buffered word
//   frame_error  : a stop bit was sampled low on the buffered word
//   overrun      : sticky, a frame completed while the buffer was full
//
// Build option: RS232_RECEIVE_FRAME_MAJORITY_EN selects 2-of-3 majority
// sampling around each slot centre (requires at least 4 clocks per bit).

module rs232_receive_frame
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 0,
  parameter int  STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rs232_txd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam real UNIT      = CLOCK_FREQ / BAUD_RATE;
  localparam int  PAR_SLOTS = (PARITY != PARITY_NONE) ? 1 : 0;
  localparam int  NSLOT     = 1 + DATA_BITS + PAR_SLOTS + STOP_BITS;
`ifdef RS232_RECEIVE_FRAME_MAJORITY_EN
  // The majority vote needs the sample after the centre, so decisions lag by one clock.
  localparam int  SAMPLE_LAG = 1;
`else
  localparam int  SAMPLE_LAG = 0;
`endif
  localparam int  LAST_FIRE = sample_point(UNIT, NSLOT - 1) + SAMPLE_LAG;
  localparam int  TW        = (LAST_FIRE < 1) ? 1 : $clog2(LAST_FIRE + 1);
  localparam int  SW        = 4;

  logic s;
  logic bit_v;

  rs232_sync #(.RESET_VALUE(1'b1)) u_sync (
    .clock_i (clock),
    .reset_i (reset),
    .d_i     (rs232_txd),
    .q_o     (s)
  );

`ifdef RS232_RECEIVE_FRAME_MAJORITY_EN
  if (UNIT < 4.0) begin : g_unit_too_small
    $error("majority sampling needs at least 4 clocks per bit");
  end

  // hist_q[0] holds s at the slot centre, hist_q[1] the cycle before it.
  logic [1:0] hist_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], s};
    end
  end
  assign bit_v = (s & hist_q[0]) | (s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign bit_v = s;
`endif

  // Decision point per slot; unused entries are never reached.
  logic [TW-1:0] sp_tab [2**SW];
  for (genvar g = 0; g < 2**SW; g++) begin : g_sp
    if (g < NSLOT) begin : g_used
      localparam int SP_G = sample_point(UNIT, g) + SAMPLE_LAG;
      assign sp_tab[g] = TW'(SP_G);
    end else begin : g_unused
      assign sp_tab[g] = '1;
    end
  end

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 fire;
  logic                 commit;
  logic                 par_exp;

  assign fire    = (timer_q == sp_tab[slot_q]);
  assign par_exp = (PARITY == PARITY_EVEN) ? (^shift_q) :
                   (PARITY == PARITY_ODD)  ? ~(^shift_q) : 1'b0;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    slot_d  = slot_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        slot_d  = '0;
        if (!s) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (fire) begin
          if (bit_v) begin
            state_d = ST_IDLE;   // line went back high: glitch, not a start bit
          end else begin
            state_d = ST_DATA;
            slot_d  = slot_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (fire) begin
          shift_d = {bit_v, shift_q[DATA_BITS-1:1]};
          slot_d  = slot_q + 1'b1;
          if (slot_q == SW'(DATA_BITS)) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (fire) begin
          perr_d  = bit_v ^ par_exp;
          slot_d  = slot_q + 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fire) begin
          if (!bit_v) begin
            ferr_d = 1'b1;
          end
          slot_d = slot_q + 1'b1;
          if (slot_q == SW'(NSLOT - 1)) begin
            state_d = ST_IDLE;   // leave now so a back-to-back start edge is seen
            commit  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = valid_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (commit) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        pe_d    = perr_q;
        fe_d    = ferr_d;    // includes the final stop sample taken this cycle
      end else begin
        ovr_d   = 1'b1;      // buffer still held: drop the new frame
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      slot_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_rs232_receive_frame.sv
// tb/tb_rs232_receive_frame.sv - self-checking bench for rs232_receive_frame

module tb_rs232_receive_frame;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] txd;
  logic [3:0] rdy;
  wire  [7:0] d0, d1, d3;
  wire  [6:0] d2;
  wire  [3:0] vld, pe, fe, ov;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // u0: 8N1, u1: 8E1, u2: 7O2 (all 10 clocks/bit); u3: 8N1 at ~11.545 clocks/bit
  rs232_receive_frame #(.CLOCK_FREQ(1000000.0), .BAUD_RATE(100000.0), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clk), .reset(rst), .rs232_txd(txd[0]), .data(d0), .valid(vld[0]), .ready(rdy[0]),
    .parity_error(pe[0]), .frame_error(fe[0]), .overrun(ov[0]));
  rs232_receive_frame #(.CLOCK_FREQ(1000000.0), .BAUD_RATE(100000.0), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clock(clk), .reset(rst), .rs232_txd(txd[1]), .data(d1), .valid(vld[1]), .ready(rdy[1]),
    .parity_error(pe[1]), .frame_error(fe[1]), .overrun(ov[1]));
  rs232_receive_frame #(.CLOCK_FREQ(1000000.0), .BAUD_RATE(100000.0), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clock(clk), .reset(rst), .rs232_txd(txd[2]), .data(d2), .valid(vld[2]), .ready(rdy[2]),
    .parity_error(pe[2]), .frame_error(fe[2]), .overrun(ov[2]));
  rs232_receive_frame #(.CLOCK_FREQ(1330000.0), .BAUD_RATE(115200.0), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u3 (
    .clock(clk), .reset(rst), .rs232_txd(txd[3]), .data(d3), .valid(vld[3]), .ready(rdy[3]),
    .parity_error(pe[3]), .frame_error(fe[3]), .overrun(ov[3]));

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } cap_t;

  typedef struct {
    int         inst;
    logic [8:0] d;
    int         nd;
    int         np;
    logic       pb;
    int         ns;
    logic [1:0] sv;
    logic [8:0] xd;
    logic       xpe;
    logic       xfe;
  } vec_t;

  cap_t cap[$];

  function automatic logic [8:0] dsel(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {2'b00, d2};
      default: return {1'b0, d3};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && rdy[i]) cap.push_back('{i, dsel(i), pe[i], fe[i]});
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within 1 ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [8:0] d, input int nd, input int np, input logic pb,
                                      input int ns, input logic [1:0] sv, output int n);
    logic [15:0] b;
    int k;
    b = '1;
    k = 0;
    b[k] = 1'b0; k++;
    for (int i = 0; i < nd; i++) begin b[k] = d[i]; k++; end
    if (np != 0) begin b[k] = pb; k++; end
    for (int i = 0; i < ns; i++) begin b[k] = sv[i]; k++; end
    n = k;
    return b;
  endfunction

  // Drives one frame; bit i ends at round((i+1)*bl) clocks after the call (called at a negedge).
  task automatic send_bits(input int inst, input logic [15:0] bits, input int nbits, input real bl);
    int cyc;
    int nxt;
    cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      txd[inst] = bits[i];
      nxt = int'(bl * real'(i + 1));
      while (cyc < nxt) begin
        @(negedge clk);
        cyc++;
      end
    end
    txd[inst] = 1'b1;
  endtask

  task automatic expect_one(input string nm, input int inst, input logic [8:0] xd, input logic xpe, input logic xfe);
    cap_t c;
    chk({nm, "_count"}, cap.size(), 1);
    if (cap.size() > 0) begin
      c = cap.pop_front();
      chk({nm, "_inst"}, c.inst, inst);
      chk({nm, "_data"}, c.d, xd);
      chk({nm, "_perr"}, c.pe, xpe);
      chk({nm, "_ferr"}, c.fe, xfe);
    end
    cap.delete();
  endtask

  vec_t       vecs [11];
  logic [15:0] bits;
  int          n;
  int          lat;
  logic [7:0]  rb;
  logic [7:0]  exp_q[$];
  real         u3_unit;
  real         fac;
  cap_t        c;

  initial begin
    vecs[0]  = '{0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 8, 0, 1'b0, 1, 2'b11, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h03C, 8, 0, 1'b0, 1, 2'b10, 9'h03C, 1'b0, 1'b1};
    vecs[4]  = '{1, 9'h003, 8, 1, 1'b1, 1, 2'b11, 9'h003, 1'b1, 1'b0};
    vecs[5]  = '{1, 9'h003, 8, 1, 1'b0, 1, 2'b11, 9'h003, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h080, 8, 1, 1'b1, 1, 2'b11, 9'h080, 1'b0, 1'b0};
    vecs[7]  = '{2, 9'h05A, 7, 1, 1'b1, 2, 2'b11, 9'h05A, 1'b0, 1'b0};
    vecs[8]  = '{2, 9'h05A, 7, 1, 1'b1, 2, 2'b01, 9'h05A, 1'b0, 1'b1};
    vecs[9]  = '{2, 9'h05A, 7, 1, 1'b0, 2, 2'b11, 9'h05A, 1'b1, 1'b0};
    vecs[10] = '{2, 9'h001, 7, 1, 1'b0, 2, 2'b10, 9'h001, 1'b0, 1'b1};

    txd = '1;
    rdy = '1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_valid", vld, 4'b0000);
    chk("rst_perr", pe, 4'b0000);
    chk("rst_ferr", fe, 4'b0000);
    chk("rst_overrun", ov, 4'b0000);
    chk("rst_d0", d0, 8'h00);
    chk("rst_d1", d1, 8'h00);
    chk("rst_d2", d2, 7'h00);
    chk("rst_d3", d3, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      bits = mk(vecs[v].d, vecs[v].nd, vecs[v].np, vecs[v].pb, vecs[v].ns, vecs[v].sv, n);
      send_bits(vecs[v].inst, bits, n, 10.0);
      repeat (25) @(negedge clk);
      expect_one($sformatf("vec%0d", v), vecs[v].inst, vecs[v].xd, vecs[v].xpe, vecs[v].xfe);
    end

    // Start-edge to valid latency on 8N1, 0xA5
    bits = mk(9'h0A5, 8, 0, 1'b0, 1, 2'b11, n);
    lat = 0;
    fork
      send_bits(0, bits, n, 10.0);
      begin
        while (!vld[0] && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_cmp++;
    if (lat < 95 || lat > 99) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles expected 95..99", lat);
    end
    repeat (20) @(negedge clk);
    expect_one("lat", 0, 9'h0A5, 1'b0, 1'b0);

    // 3-cycle glitch is rejected, then a real frame is taken
    txd[0] = 1'b0;
    repeat (3) @(negedge clk);
    txd[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_count", cap.size(), 0);
    chk("glitch_valid", vld[0], 1'b0);
    bits = mk(9'h055, 8, 0, 1'b0, 1, 2'b11, n);
    send_bits(0, bits, n, 10.0);
    repeat (25) @(negedge clk);
    expect_one("after_glitch", 0, 9'h055, 1'b0, 1'b0);

    // Overrun: consumer stalled across two back-to-back frames
    rdy[0] = 1'b0;
    bits = mk(9'h011, 8, 0, 1'b0, 1, 2'b11, n);
    send_bits(0, bits, n, 10.0);
    chk("ovr_first_valid", vld[0], 1'b1);
    chk("ovr_first_flag", ov[0], 1'b0);
    bits = mk(9'h022, 8, 0, 1'b0, 1, 2'b11, n);
    send_bits(0, bits, n, 10.0);
    repeat (25) @(negedge clk);
    chk("ovr_valid", vld[0], 1'b1);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_flag", ov[0], 1'b1);
    chk("ovr_count", cap.size(), 0);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", vld[0], 1'b0);
    chk("ovr_sticky", ov[0], 1'b1);
    cap.delete();

    // Reset in the middle of a frame: nothing delivered, overrun cleared
    bits = mk(9'h0FF, 8, 0, 1'b0, 1, 2'b11, n);
    fork
      send_bits(0, bits, n, 10.0);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    chk("midrst_count", cap.size(), 0);
    chk("midrst_valid", vld[0], 1'b0);
    chk("midrst_overrun", ov[0], 1'b0);
    cap.delete();

    // Non-integer clocks/bit with +/-2% transmitter rate error
    u3_unit = 1330000.0 / 115200.0;
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      case (i % 3)
        0:       fac = 1.0;
        1:       fac = 1.02;
        default: fac = 0.98;
      endcase
      bits = mk({1'b0, rb}, 8, 0, 1'b0, 1, 2'b11, n);
      send_bits(3, bits, n, u3_unit / fac);
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("rnd_count", cap.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (cap.size() > 0) begin
        c = cap.pop_front();
        chk($sformatf("rnd%0d_inst", i), c.inst, 3);
        chk($sformatf("rnd%0d_data", i), c.d, {1'b0, exp_q[i]});
        chk($sformatf("rnd%0d_err", i), {c.pe, c.fe}, 2'b00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
